pre_process_ctrl: RTL and testbench

Frame sequencer for the pre-processing datapath (Haar downscale → skin detect / grayscale → integral-image generator). Pulls packed pixel words from the capture FIFO, feeds exactly one frame per run into the datapath, and holds the IIG run enable for that frame. Counts IIG write strobes to detect frame completion and manages a two-bank ping-pong integral-image buffer shared with the face detector. When no bank is free, a whole frame is read and discarded so the capture FIFO never stalls.

---
 rtl/pre_process_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pre_process_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_process_ctrl.sv
// rtl/pre_process_ctrl.sv - frame sequencer feeding one frame per run into the
// pre-processing datapath, with ping-pong integral-image bank tracking.
module pre_process_ctrl #(
  parameter int FRAME_WORDS   = 19200,
  parameter int IIG_WORDS     = 4800,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iFifo_empty,
  input  logic [31:0] iFifo_data,
  output logic        oFifo_rdreq,
  output logic        oInput_ready,
  output logic [31:0] oData_in,
  output logic        oRun_IIG,
  input  logic        iIIG_wrreq,
  output logic        oBank_sel,
  output logic [1:0]  oBank_full,
  input  logic        iRelease,
  input  logic        iRelease_bank,
  output logic        oFrame_done,
  output logic [15:0] oFrame_count,
  output logic [15:0] oDrop_count,
  output logic        oError
);

  localparam int RD_W = $clog2(FRAME_WORDS + 1);
  localparam int WR_W = $clog2(IIG_WORDS + 1);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [RD_W-1:0] RD_MAX  = RD_W'(FRAME_WORDS);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(FRAME_WORDS - 1);
  localparam logic [WR_W-1:0] WR_MAX  = WR_W'(IIG_WORDS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [WR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [TO_W-1:0] drain_cnt_q, drain_cnt_d;
  logic        input_ready_q, input_ready_d;
  logic        bank_sel_q, bank_sel_d;
  logic [1:0]  bank_full_q, bank_full_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        error_q, error_d;

  logic rdreq;
  logic iig_active;
  logic last_req;
  logic complete;

  always_comb begin
    iig_active = (state_q == S_STREAM) || (state_q == S_DRAIN);
    rdreq      = ((state_q == S_STREAM) || (state_q == S_DROP)) &&
                 !iFifo_empty && (rd_cnt_q < RD_MAX);
    last_req   = rdreq && (rd_cnt_q == RD_LAST);
    complete   = (state_q == S_DRAIN) && (wr_cnt_q == WR_MAX);
  end

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    bank_sel_d    = bank_sel_q;
    bank_full_d   = bank_full_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    error_d       = error_q;
    input_ready_d = rdreq && (state_q == S_STREAM);

    if (rdreq) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (iIIG_wrreq && iig_active && (wr_cnt_q != WR_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    // Release is applied first so a completion-set on the same bank overrides it.
    if (iRelease) begin
      bank_full_d[iRelease_bank] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (iEnable) begin
          if (!bank_full_q[bank_sel_q]) begin
            state_d  = S_STREAM;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
          end else if (!iFifo_empty) begin
            state_d  = S_DROP;
            rd_cnt_d = '0;
          end
        end
      end
      S_STREAM: begin
        if (last_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (complete) begin
          bank_full_d[bank_sel_q] = 1'b1;
          bank_sel_d    = ~bank_sel_q;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = S_IDLE;
        end else if (drain_cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (last_req) begin
          drop_count_d = drop_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q       <= S_IDLE;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      drain_cnt_q   <= '0;
      input_ready_q <= 1'b0;
      bank_sel_q    <= 1'b0;
      bank_full_q   <= 2'b00;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      drop_count_q  <= 16'd0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      input_ready_q <= input_ready_d;
      bank_sel_q    <= bank_sel_d;
      bank_full_q   <= bank_full_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      error_q       <= error_d;
    end
  end

  assign oFifo_rdreq  = rdreq;
  assign oInput_ready = input_ready_q;
  assign oData_in     = iFifo_data;
  assign oRun_IIG     = iig_active;
  assign oBank_sel    = bank_sel_q;
  assign oBank_full   = bank_full_q;
  assign oFrame_done  = frame_done_q;
  assign oFrame_count = frame_count_q;
  assign oDrop_count  = drop_count_q;
  assign oError       = error_q;

endmodule

// File: tb/tb_pre_process_ctrl.sv
// tb/tb_pre_process_ctrl.sv - randomized bench for pre_process_ctrl with a
// FIFO/IIG environment model and a frame-level bank/counter reference model.
module tb_pre_process_ctrl;

  localparam int FW = 8;
  localparam int IW = 2;
  localparam int TO = 16;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iEnable = 1'b0;
  logic        iFifo_empty = 1'b1;
  logic [31:0] iFifo_data = 32'd0;
  logic        oFifo_rdreq;
  logic        oInput_ready;
  logic [31:0] oData_in;
  logic        oRun_IIG;
  logic        iIIG_wrreq = 1'b0;
  logic        oBank_sel;
  logic [1:0]  oBank_full;
  logic        iRelease = 1'b0;
  logic        iRelease_bank = 1'b0;
  logic        oFrame_done;
  logic [15:0] oFrame_count;
  logic [15:0] oDrop_count;
  logic        oError;

  pre_process_ctrl #(
    .FRAME_WORDS  (FW),
    .IIG_WORDS    (IW),
    .DRAIN_TIMEOUT(TO)
  ) dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iEnable      (iEnable),
    .iFifo_empty  (iFifo_empty),
    .iFifo_data   (iFifo_data),
    .oFifo_rdreq  (oFifo_rdreq),
    .oInput_ready (oInput_ready),
    .oData_in     (oData_in),
    .oRun_IIG     (oRun_IIG),
    .iIIG_wrreq   (iIIG_wrreq),
    .oBank_sel    (oBank_sel),
    .oBank_full   (oBank_full),
    .iRelease     (iRelease),
    .iRelease_bank(iRelease_bank),
    .oFrame_done  (oFrame_done),
    .oFrame_count (oFrame_count),
    .oDrop_count  (oDrop_count),
    .oError       (oError)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  // environment state
  logic [31:0] fifo_q[$];
  logic [31:0] rx_q[$];
  int  rdreq_n, viol_n, done_n, run_n;
  int  frame_rx, wr_pend, burst_cnt;
  bit  iig_auto, burst_mode, hold_empty, last_wr;
  bit  rel_now, rel_now_bank, rel_arm, rel_arm_bank;

  // reference model
  logic [1:0]  m_full;
  logic        m_sel;
  logic [15:0] m_fc, m_dc;
  logic        m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of environment: sample DUT outputs, drive IIG/release,
  // then model the FIFO reacting to the request the DUT will sample next edge.
  task automatic tick();
    @(negedge iClk);
    if (oInput_ready) rx_q.push_back(oData_in);
    if (oFrame_done) done_n++;
    if (oRun_IIG) run_n++;

    iIIG_wrreq = 1'b0;
    iRelease   = 1'b0;
    if (rel_now) begin
      iRelease      = 1'b1;
      iRelease_bank = rel_now_bank;
      rel_now       = 1'b0;
    end
    if (last_wr) begin
      last_wr = 1'b0;
      if (rel_arm) begin
        iRelease      = 1'b1;
        iRelease_bank = rel_arm_bank;
        rel_arm       = 1'b0;
      end
    end
    if (oInput_ready && iig_auto) begin
      frame_rx++;
      if (frame_rx == FW) begin
        wr_pend  = IW;
        frame_rx = 0;
      end
    end
    if (wr_pend > 0) begin
      iIIG_wrreq = 1'b1;
      wr_pend--;
      if (wr_pend == 0) last_wr = 1'b1;
    end

    burst_cnt++;
    if (!burst_mode) hold_empty = 1'b0;
    else if (burst_cnt % 3 == 0) hold_empty = ~hold_empty;
    iFifo_empty = (fifo_q.size() == 0) || hold_empty;
    #1;
    if (oFifo_rdreq) begin
      rdreq_n++;
      if (iFifo_empty) viol_n++;
      else iFifo_data = fifo_q.pop_front();
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".bank_full"}, 32'(oBank_full), 32'(m_full));
    check_eq({tag, ".bank_sel"}, 32'(oBank_sel), 32'(m_sel));
    check_eq({tag, ".frame_count"}, 32'(oFrame_count), 32'(m_fc));
    check_eq({tag, ".drop_count"}, 32'(oDrop_count), 32'(m_dc));
    check_eq({tag, ".error"}, 32'(oError), 32'(m_err));
  endtask

  task automatic pulse_release(input bit b, input string tag);
    rel_now      = 1'b1;
    rel_now_bank = b;
    tick();
    tick();
    m_full[b] = 1'b0;
    check_model(tag);
  endtask

  // arm < 0: no release; otherwise release bank 'arm' in the completion cycle.
  task automatic run_frame(input bit iig_on, input bit burst, input int arm, input string tag);
    logic [31:0] words[$];
    logic [31:0] w;
    bit drop;
    int n;
    drop = m_full[m_sel];
    for (int i = 0; i < FW; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      words.push_back(w);
    end
    rx_q.delete();
    rdreq_n = 0; viol_n = 0; done_n = 0; run_n = 0; frame_rx = 0;
    iig_auto = iig_on;
    if (!drop && iig_on && arm >= 0) begin
      rel_arm      = 1'b1;
      rel_arm_bank = arm[0];
    end
    tick();
    iEnable = 1'b1;
    tick();
    iEnable = 1'b0;
    burst_mode = burst;
    n = 0;
    while ((rdreq_n < FW || oRun_IIG) && n < 400) begin
      tick();
      n++;
    end
    check_eq({tag, ".end_bound"}, 32'(n < 400), 32'd1);
    repeat (3) tick();
    burst_mode = 1'b0;

    check_eq({tag, ".rdreq_n"}, 32'(rdreq_n), 32'(FW));
    check_eq({tag, ".rdreq_empty"}, 32'(viol_n), 32'd0);
    if (drop) begin
      check_eq({tag, ".drop_ready_n"}, 32'(rx_q.size()), 32'd0);
      check_eq({tag, ".drop_run_iig"}, 32'(run_n), 32'd0);
      check_eq({tag, ".drop_done"}, 32'(done_n), 32'd0);
      m_dc = m_dc + 16'd1;
    end else begin
      check_eq({tag, ".ready_n"}, 32'(rx_q.size()), 32'(FW));
      for (int i = 0; i < FW && i < rx_q.size(); i++)
        check_eq($sformatf("%s.word%0d", tag, i), rx_q[i], words[i]);
      check_eq({tag, ".done_n"}, 32'(done_n), iig_on ? 32'd1 : 32'd0);
      if (iig_on) begin
        if (arm >= 0) m_full[arm[0]] = 1'b0;
        m_full[m_sel] = 1'b1;
        m_sel = ~m_sel;
        m_fc  = m_fc + 16'd1;
      end else begin
        m_err = 1'b1;
      end
    end
    check_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".rdreq"}, 32'(oFifo_rdreq), 32'd0);
    check_eq({tag, ".input_ready"}, 32'(oInput_ready), 32'd0);
    check_eq({tag, ".run_iig"}, 32'(oRun_IIG), 32'd0);
    check_eq({tag, ".frame_done"}, 32'(oFrame_done), 32'd0);
    check_model(tag);
  endtask

  initial begin
    int n;
    m_full = 2'b00; m_sel = 1'b0; m_fc = 16'd0; m_dc = 16'd0; m_err = 1'b0;
    wr_pend = 0; burst_cnt = 0; frame_rx = 0;
    iig_auto = 0; burst_mode = 0; hold_empty = 0; last_wr = 0;
    rel_now = 0; rel_now_bank = 0; rel_arm = 0; rel_arm_bank = 0;

    #1;
    check_all_zero("reset");
    repeat (2) tick();
    iReset = 1'b0;
    tick();

    run_frame(1, 0, -1, "basic");
    run_frame(1, 0, -1, "pingpong");
    run_frame(1, 0, -1, "drop");
    pulse_release(1'b0, "rel0");
    run_frame(1, 0, -1, "refill0");
    pulse_release(1'b1, "rel1");
    run_frame(1, 0, 1, "same_bank_rel");
    pulse_release(1'b0, "rel0b");
    run_frame(1, 0, 1, "other_bank_rel");
    run_frame(1, 1, -1, "bursty");
    pulse_release(1'b0, "rel0c");
    pulse_release(1'b1, "rel1c");
    run_frame(0, 0, -1, "timeout");
    pulse_release(1'b1, "rel_empty");

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) pulse_release($urandom_range(0, 1) == 1, $sformatf("rnd_rel%0d", i));
      run_frame(1, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 1)),
                $sformatf("rnd%0d", i));
    end

    // asynchronous reset in the middle of a streamed frame
    pulse_release(1'b0, "pre_rst0");
    pulse_release(1'b1, "pre_rst1");
    for (int i = 0; i < FW; i++) fifo_q.push_back($urandom);
    rx_q.delete(); iig_auto = 1'b0;
    tick();
    iEnable = 1'b1;
    tick();
    iEnable = 1'b0;
    n = 0;
    while (rx_q.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    check_eq("midrst.bound", 32'(n < 100), 32'd1);
    iReset = 1'b1;
    #1;
    m_full = 2'b00; m_sel = 1'b0; m_fc = 16'd0; m_dc = 16'd0; m_err = 1'b0;
    check_all_zero("midrst");
    fifo_q.delete();
    wr_pend = 0; last_wr = 0; rel_arm = 0; frame_rx = 0;
    repeat (2) tick();
    iReset = 1'b0;
    tick();
    run_frame(1, 0, -1, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
